// File: rtl/spi_master_loader.sv
// SPI mode-0 initiator, MSB first, 8-bit frames, byte handshake.
// Optional chip-select hold across bytes for burst transfers.
module spi_master_loader #(
    parameter int CLK_DIV      = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    input  logic       KEEP_CS,
    input  logic       STOP,
    output logic       READY,
    output logic       DONE,
    output logic [7:0] RX_DATA,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    output logic       SPI_CS,
    input  logic       SPI_MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        BURST
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_END = 8'(CS_SETUP_CYC);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD_CYC - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic       keep;

    // Frame sequencer: CS setup, SCK low/high phases, CS hold, burst wait.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            keep     <= 1'b0;
            RX_DATA  <= '0;
            DONE     <= 1'b0;
            READY    <= 1'b1;
            SPI_SCK  <= 1'b0;
            SPI_MOSI <= 1'b0;
            SPI_CS   <= 1'b1;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        tx_sh   <= TX_DATA;
                        keep    <= KEEP_CS;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        READY   <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    SPI_CS   <= 1'b0;
                    SPI_MOSI <= tx_sh[7];
                    if (cnt == SETUP_END) begin
                        cnt   <= '0;
                        state <= LOW;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LOW: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        SPI_SCK <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], SPI_MISO};
                        state   <= HIGH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        SPI_SCK <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            RX_DATA <= rx_sh;
                            DONE    <= 1'b1;
                            if (keep) begin
                                READY <= 1'b1;
                                state <= BURST;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                            SPI_MOSI <= tx_sh[6];
                            state    <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt    <= '0;
                        SPI_CS <= 1'b1;
                        READY  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BURST: begin
                    if (START) begin
                        tx_sh    <= TX_DATA;
                        keep     <= KEEP_CS;
                        SPI_MOSI <= TX_DATA[7];
                        bit_cnt  <= '0;
                        cnt      <= '0;
                        READY    <= 1'b0;
                        state    <= LOW;
                    end else if (STOP) begin
                        cnt   <= '0;
                        READY <= 1'b0;
                        state <= HOLD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_loader.sv
// Directed bench for spi_master_loader: timing, data, burst, abort.
// A second instance covers the minimum-parameter corner.
module tb_spi_master_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx = 8'h00;
    logic       keep = 1'b0;
    logic       stop = 1'b0;
    logic       ready, done, sck, mosi, cs, miso;
    logic [7:0] rx;

    logic       start2 = 1'b0;
    logic [7:0] tx2 = 8'h00;
    logic       ready2, done2, sck2, mosi2, cs2;
    logic [7:0] rx2;

    logic       loop = 1'b0;
    logic [7:0] slv = 8'h3C;
    logic [2:0] bidx = 3'd0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int acc_at, done_at, cs_hi_at, stop_at, first_rise_at;
    int done_cnt = 0, cs_hi_cnt = 0, rises = 0;
    logic need_rise = 1'b0;
    logic cs_q = 1'b1, sck_q = 1'b0;
    logic [7:0] mosi_cap = 8'h00;

    int acc2_at, done2_at, cs2_at, first2_at, last2_at;
    int done2_cnt = 0, rises2 = 0;
    logic cs2_q = 1'b1, sck2_q = 1'b0, need2 = 1'b0;

    always #5 clk = ~clk;

    assign miso = loop ? mosi : slv[3'd7 - bidx];

    spi_master_loader dut (
        .CLK(clk), .RST(rst), .START(start), .TX_DATA(tx),
        .KEEP_CS(keep), .STOP(stop), .READY(ready), .DONE(done),
        .RX_DATA(rx), .SPI_SCK(sck), .SPI_MOSI(mosi),
        .SPI_CS(cs), .SPI_MISO(miso)
    );

    spi_master_loader #(
        .CLK_DIV(1), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)
    ) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .TX_DATA(tx2),
        .KEEP_CS(1'b0), .STOP(1'b0), .READY(ready2), .DONE(done2),
        .RX_DATA(rx2), .SPI_SCK(sck2), .SPI_MOSI(mosi2),
        .SPI_CS(cs2), .SPI_MISO(mosi2)
    );

    // Edge index: a value set by edge n is logged as n.
    always @(posedge clk) cyc <= cyc + 1;

    // Event log for the default-parameter instance.
    always @(posedge clk) begin
        cs_q  <= cs;
        sck_q <= sck;
        if (start && ready) begin
            acc_at    <= cyc + 1;
            need_rise <= 1'b1;
        end
        if (stop && !start && ready) stop_at <= cyc + 1;
        if (sck && !sck_q) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[6:0], mosi};
            if (need_rise) begin
                first_rise_at <= cyc;
                need_rise     <= 1'b0;
            end
        end
        if (rst) bidx <= 3'd0;
        else if (sck && !sck_q) bidx <= bidx + 3'd1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc;
        end
        if (cs && !cs_q) begin
            cs_hi_cnt <= cs_hi_cnt + 1;
            cs_hi_at  <= cyc;
        end
    end

    // Event log for the minimum-parameter instance.
    always @(posedge clk) begin
        cs2_q  <= cs2;
        sck2_q <= sck2;
        if (start2 && ready2) begin
            acc2_at <= cyc + 1;
            need2   <= 1'b1;
        end
        if (sck2 && !sck2_q) begin
            rises2   <= rises2 + 1;
            last2_at <= cyc;
            if (need2) begin
                first2_at <= cyc;
                need2     <= 1'b0;
            end
        end
        if (done2) begin
            done2_cnt <= done2_cnt + 1;
            done2_at  <= cyc;
        end
        if (cs2 && !cs2_q) cs2_at <= cyc;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic k);
        @(negedge clk);
        start = 1'b1;
        tx    = d;
        keep  = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0 = done_cnt;
        int t = 0;
        while (done_cnt == n0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == n0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_cs_high(input string tag);
        int n0 = cs_hi_cnt;
        int t = 0;
        while (cs_hi_cnt == n0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (cs_hi_cnt == n0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_rises(input int n, input string tag);
        int t = 0;
        while (rises < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (rises < n) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int r0, d0, h0;
        logic [7:0] lb [3];
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h81;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_rx", rx, 0);

        // Single byte, slave answers 0x3C
        loop = 1'b0;
        slv  = 8'h3C;
        send(8'hA5, 1'b0);
        wait_done("single");
        check("single_rise", first_rise_at - acc_at, 7);
        check("single_done", done_at - acc_at, 67);
        check("single_rx", rx, 8'h3C);
        check("single_mosi", mosi_cap, 8'hA5);
        wait_cs_high("single_cs");
        check("single_cs", cs_hi_at - acc_at, 69);
        check("single_ready", ready, 1);

        // Loopback
        loop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r0 = rises;
            send(lb[i], 1'b0);
            wait_done("loop");
            check("loop_rx", rx, lb[i]);
            check("loop_rises", rises - r0, 8);
            wait_cs_high("loop_cs");
        end

        // Burst of three bytes, then STOP
        h0 = cs_hi_cnt;
        d0 = done_cnt;
        send(8'h12, 1'b1);
        wait_done("burst1");
        check("burst1_rx", rx, 8'h12);
        send(8'h34, 1'b1);
        wait_done("burst2");
        check("burst2_rise", first_rise_at - acc_at, 4);
        check("burst2_rx", rx, 8'h34);
        send(8'h56, 1'b1);
        wait_done("burst3");
        check("burst3_rise", first_rise_at - acc_at, 4);
        check("burst3_rx", rx, 8'h56);
        repeat (10) @(negedge clk);
        check("burst_cs_low", cs, 0);
        check("burst_ready", ready, 1);
        check("burst_no_cs_high", cs_hi_cnt - h0, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cs_high("burst_stop");
        check("burst_stop_cs", cs_hi_at - stop_at, 2);
        check("burst_dones", done_cnt - d0, 3);

        // START while busy is dropped
        d0 = done_cnt;
        r0 = rises;
        send(8'h11, 1'b0);
        wait_rises(r0 + 2, "busy");
        start = 1'b1;
        tx    = 8'hEE;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy");
        check("busy_rx", rx, 8'h11);
        check("busy_mosi", mosi_cap, 8'h11);
        wait_cs_high("busy_cs");
        repeat (80) @(negedge clk);
        check("busy_dones", done_cnt - d0, 1);
        check("busy_cs_idle", cs, 1);

        // START with STOP in BURST
        send(8'h22, 1'b1);
        wait_done("ss1");
        h0 = cs_hi_cnt;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        tx    = 8'h77;
        keep  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wait_done("ss2");
        check("ss_rx", rx, 8'h77);
        check("ss_cs_low", cs_hi_cnt - h0, 0);
        wait_cs_high("ss_cs");
        check("ss_hold", cs_hi_at - done_at, 2);

        // Reset after three SCK rises
        loop = 1'b0;
        d0 = done_cnt;
        r0 = rises;
        send(8'hAA, 1'b0);
        wait_rises(r0 + 3, "abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs", cs, 1);
        check("abort_sck", sck, 0);
        check("abort_mosi", mosi, 0);
        check("abort_ready", ready, 1);
        check("abort_rx", rx, 0);
        loop = 1'b1;
        send(8'hC3, 1'b0);
        wait_done("after_abort");
        check("after_abort_rx", rx, 8'hC3);
        check("abort_dones", done_cnt - d0, 1);
        wait_cs_high("after_abort_cs");

        // Minimum parameters on the second instance
        d0 = done2_cnt;
        r0 = rises2;
        @(negedge clk);
        start2 = 1'b1;
        tx2    = 8'h5A;
        @(negedge clk);
        start2 = 1'b0;
        for (int t = 0; t < 60 && done2_cnt == d0; t++) @(negedge clk);
        check("edge_done_seen", done2_cnt - d0, 1);
        repeat (4) @(negedge clk);
        check("edge_rise", first2_at - acc2_at, 3);
        check("edge_done", done2_at - acc2_at, 18);
        check("edge_cs", cs2_at - acc2_at, 19);
        check("edge_rx", rx2, 8'h5A);
        check("edge_rises", rises2 - r0, 8);
        check("edge_span", last2_at - first2_at, 14);
        check("edge_ready", ready2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
